// File: rtl/uart_tx_ascii_lines_feed.sv
// rtl/uart_tx_ascii_lines_feed.sv - snapshot two ASCII display lines and stream them as bytes into a UART TX FIFO
module uart_tx_ascii_lines_feed #(
    parameter int PARM_LINE_CHARS = 16,
    parameter bit PARM_EOL_CRLF   = 1'b1
) (
    input  logic                         i_clk_20mhz,
    input  logic                         i_rst_20mhz_n,
    input  logic [PARM_LINE_CHARS*8-1:0] i_ascii_line1,
    input  logic [PARM_LINE_CHARS*8-1:0] i_ascii_line2,
    input  logic                         i_start,
    input  logic                         i_tx_ready,
    output logic [7:0]                   o_tx_data,
    output logic                         o_tx_valid,
    output logic                         o_busy,
    output logic                         o_done
);
    localparam int LW = PARM_LINE_CHARS * 8;
    localparam int IW = (PARM_LINE_CHARS > 2) ? $clog2(PARM_LINE_CHARS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PARM_LINE_CHARS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LINE1,
        ST_EOL1,
        ST_LINE2,
        ST_EOL2,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   line1_q, line1_d;
    logic [LW-1:0]   line2_q, line2_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      hold_q, hold_d;

    logic [LW-1:0]   cur_line;
    logic [LW-1:0]   shifted;
    logic [7:0]      raw_char;
    logic [7:0]      cur_byte;
    logic            sending;
    logic            fire;

    // Byte selection: character 0 sits in the top byte, so shift the index to the MSB end.
    always_comb begin
        sending  = (state_q == ST_LINE1) || (state_q == ST_EOL1) ||
                   (state_q == ST_LINE2) || (state_q == ST_EOL2);
        cur_line = (state_q == ST_LINE2) ? line2_q : line1_q;
        shifted  = cur_line << {idx_q, 3'b000};
        raw_char = shifted[LW-1 -: 8];
        if ((state_q == ST_EOL1) || (state_q == ST_EOL2)) begin
            cur_byte = idx_q[0] ? 8'h0A : 8'h0D;
        end else if ((raw_char < 8'h20) || (raw_char > 8'h7E)) begin
            cur_byte = 8'h2E;
        end else begin
            cur_byte = raw_char;
        end
        fire   = sending && i_tx_ready;
        hold_d = sending ? cur_byte : hold_q;
    end

    always_comb begin
        state_d = state_q;
        line1_d = line1_q;
        line2_d = line2_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    line1_d = i_ascii_line1;
                    line2_d = i_ascii_line2;
                    idx_d   = '0;
                    state_d = ST_LINE1;
                end
            end
            ST_LINE1, ST_LINE2: begin
                if (fire) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (PARM_EOL_CRLF) begin
                            state_d = (state_q == ST_LINE1) ? ST_EOL1 : ST_EOL2;
                        end else begin
                            state_d = (state_q == ST_LINE1) ? ST_LINE2 : ST_DONE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_EOL1, ST_EOL2: begin
                // idx 0 offers CR, idx 1 offers LF
                if (fire) begin
                    if (idx_q[0]) begin
                        idx_d   = '0;
                        state_d = (state_q == ST_EOL1) ? ST_LINE2 : ST_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (!i_rst_20mhz_n) begin
            state_q <= ST_IDLE;
            line1_q <= '0;
            line2_q <= '0;
            idx_q   <= '0;
            hold_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            line1_q <= line1_d;
            line2_q <= line2_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    assign o_tx_valid = sending;
    assign o_tx_data  = sending ? cur_byte : hold_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_uart_tx_ascii_lines_feed.sv
// tb/tb_uart_tx_ascii_lines_feed.sv - scoreboard bench for uart_tx_ascii_lines_feed
module tb_uart_tx_ascii_lines_feed;
    logic         clk = 1'b0;
    logic         rstn;
    logic [127:0] l1, l2, l1n, l2n;
    logic         start, start_n, ready, ready_n;
    logic [7:0]   tx_data, tx_data_n;
    logic         tx_valid, tx_valid_n, busy, busy_n, done, done_n;

    int vectors = 0;
    int miscompares = 0;
    int xfers = 0;
    int xfers_n = 0;
    int ready_mode = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_n_q[$];

    always #5 clk = ~clk;

    uart_tx_ascii_lines_feed #(.PARM_LINE_CHARS(16), .PARM_EOL_CRLF(1'b1)) dut (
        .i_clk_20mhz(clk), .i_rst_20mhz_n(rstn), .i_ascii_line1(l1), .i_ascii_line2(l2),
        .i_start(start), .i_tx_ready(ready), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
        .o_busy(busy), .o_done(done));

    uart_tx_ascii_lines_feed #(.PARM_LINE_CHARS(16), .PARM_EOL_CRLF(1'b0)) dut_n (
        .i_clk_20mhz(clk), .i_rst_20mhz_n(rstn), .i_ascii_line1(l1n), .i_ascii_line2(l2n),
        .i_start(start_n), .i_tx_ready(ready_n), .o_tx_data(tx_data_n), .o_tx_valid(tx_valid_n),
        .o_busy(busy_n), .o_done(done_n));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] sanitise(input logic [7:0] c);
        return ((c < 8'h20) || (c > 8'h7E)) ? 8'h2E : c;
    endfunction

    // Reference: each line character by character, then optional CR LF.
    task automatic push_exp(input logic [127:0] a, input logic [127:0] b, input bit crlf, input bit to_n);
        logic [127:0] lines [2];
        lines[0] = a;
        lines[1] = b;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                if (to_n) exp_n_q.push_back(sanitise(lines[k][127-8*i -: 8]));
                else      exp_q.push_back(sanitise(lines[k][127-8*i -: 8]));
            end
            if (crlf) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
    endtask

    function automatic logic [127:0] rand_line();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) r[127-8*i -: 8] = 8'($urandom_range(0, 255));
            else                           r[127-8*i -: 8] = 8'($urandom_range(32, 126));
        end
        return r;
    endfunction

    initial begin
        ready = 1'b1;
        ready_n = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: ready = ($urandom_range(0, 2) != 0);
            endcase
            ready_n = ($urandom_range(0, 2) != 0);
            cyc++;
        end
    end

    bit done_pend, busy_pend, prev_stall;
    logic [7:0] prev_data;
    always @(negedge clk) begin
        if (!rstn) begin
            done_pend = 0; busy_pend = 0; prev_stall = 0;
        end else begin
            check("done", done, done_pend);
            if (done_pend) check("valid_in_done", tx_valid, 1'b0);
            if (busy_pend) check("busy_fall", busy, 1'b0);
            busy_pend = done_pend;
            done_pend = 0;
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1'b1);
                check("stall_data", tx_data, prev_data);
            end
            if (tx_valid && ready) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_xfer: got byte %0h, expected none at %0t", tx_data, $time);
                end else begin
                    check("tx_data", tx_data, exp_q.pop_front());
                    xfers++;
                    if (exp_q.size() == 0) done_pend = 1;
                end
            end
            prev_stall = tx_valid && !ready;
            prev_data = tx_data;
        end
    end

    bit done_pend_n, busy_pend_n, prev_stall_n;
    logic [7:0] prev_data_n;
    always @(negedge clk) begin
        if (!rstn) begin
            done_pend_n = 0; busy_pend_n = 0; prev_stall_n = 0;
        end else begin
            check("n_done", done_n, done_pend_n);
            if (busy_pend_n) check("n_busy_fall", busy_n, 1'b0);
            busy_pend_n = done_pend_n;
            done_pend_n = 0;
            if (prev_stall_n) check("n_stall_data", {tx_valid_n, tx_data_n}, {1'b1, prev_data_n});
            if (tx_valid_n && ready_n) begin
                if (exp_n_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL n_unexpected_xfer: got byte %0h, expected none at %0t", tx_data_n, $time);
                end else begin
                    check("n_tx_data", tx_data_n, exp_n_q.pop_front());
                    xfers_n++;
                    if (exp_n_q.size() == 0) done_pend_n = 1;
                end
            end
            prev_stall_n = tx_valid_n && !ready_n;
            prev_data_n = tx_data_n;
        end
    end

    task automatic wait_idle();
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && exp_n_q.size() == 0 && !busy && !busy_n &&
                !done_pend && !busy_pend && !done_pend_n && !busy_pend_n) return;
        end
        vectors++; miscompares++;
        $display("FAIL wait_idle: timeout, %0d/%0d bytes still expected", exp_q.size(), exp_n_q.size());
    endtask

    task automatic wait_xfers(input int target);
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            #2;
            if (xfers >= target) return;
        end
        vectors++; miscompares++;
        $display("FAIL wait_xfers: got %0d, expected %0d", xfers, target);
    endtask

    task automatic go(input logic [127:0] a, input logic [127:0] b);
        l1 = a; l2 = b;
        push_exp(a, b, 1'b1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
        check("valid_latency", tx_valid, 1'b1);
    endtask

    task automatic go_n(input logic [127:0] a, input logic [127:0] b);
        l1n = a; l2n = b;
        push_exp(a, b, 1'b0, 1'b1);
        start_n = 1'b1;
        @(negedge clk);
        #2;
        start_n = 1'b0;
        check("n_valid_latency", tx_valid_n, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] text1, text2, san1;
        int base;
        text1 = "X:0123  Y:ABCD  ";
        text2 = "Z:0F00  T:0210  ";
        rstn = 1'b0; start = 1'b0; start_n = 1'b0;
        l1 = '0; l2 = '0; l1n = '0; l2n = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            check("idle_outputs", {tx_valid, busy, done, tx_data}, 11'h000);
        end

        ready_mode = 0;
        base = xfers;
        go(text1, text2);
        wait_idle();
        check("count_ready_high", xfers - base, 36);

        ready_mode = 1;
        base = xfers;
        go(text1, text2);
        wait_idle();
        check("count_backpressure", xfers - base, 36);

        ready_mode = 0;
        base = xfers;
        go(text1, text2);
        wait_xfers(base + 5);
        l1 = {16{8'h5F}};
        l2 = {16{8'h5F}};
        start = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check("count_snapshot", xfers - base, 36);

        san1 = "ABCDEFGHIJKLMNOP";
        san1[127-24 -: 8] = 8'h0A;
        san1[127-56 -: 8] = 8'h7F;
        base = xfers_n;
        go_n(san1, text2);
        wait_idle();
        check("n_count", xfers_n - base, 32);

        ready_mode = 2;
        for (int k = 0; k < 5; k++) begin
            go(rand_line(), rand_line());
            go_n(rand_line(), rand_line());
            wait_idle();
        end

        ready_mode = 0;
        base = xfers;
        go(text1, text2);
        wait_xfers(base + 20);
        rstn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #2;
        check("reset_abort", {tx_valid, busy, done}, 3'b000);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        check("after_reset_idle", {tx_valid, busy, done}, 3'b000);
        ready_mode = 2;
        base = xfers;
        go(text1, text2);
        wait_idle();
        check("count_after_reset", xfers - base, 36);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_ascii_lines_feed.md
Name: uart_tx_ascii_lines_feed

Overview:
- Sequential stage directly downstream of the ADXL362 readings-to-ASCII converter.
- Snapshots two 16-character ASCII display lines on a start pulse and streams them byte-serially, each line terminated by an optional CR/LF pair, into the UART transmit FIFO over a valid/ready handshake.
- Lets the same text shown on the PMOD CLS also be logged over the serial console at the console's pace.

Parameters:
- PARM_LINE_CHARS, 16, characters per line; line ports are PARM_LINE_CHARS*8 bits wide.
- PARM_EOL_CRLF, 1, 1 = append 8'h0D, 8'h0A after each line; 0 = no terminator.

Ports:
- i_clk_20mhz  input  1  system clock; all logic on rising edge.
- i_rst_20mhz_n  input  1  reset, synchronous, active-low.
- i_ascii_line1  input  PARM_LINE_CHARS*8  first line; character 0 in bits [MSB-:8].
- i_ascii_line2  input  PARM_LINE_CHARS*8  second line, same packing.
- i_start  input  1  single-cycle request to send both lines.
- i_tx_ready  input  1  UART TX FIFO can accept a byte this cycle (not full).
- o_tx_data  output  8  byte offered to the FIFO.
- o_tx_valid  output  1  o_tx_data is valid.
- o_busy  output  1  transfer in progress; high from the cycle after an accepted start until the done cycle inclusive.
- o_done  output  1  one-cycle pulse after the last byte handshake.

Behaviour:
- Reset (i_rst_20mhz_n low at a clock edge) forces state IDLE and clears outputs: o_tx_valid=0, o_tx_data=8'h00, o_busy=0, o_done=0; the snapshot registers and byte index are cleared.
- Reset mid-transfer aborts immediately. No further bytes are offered and no o_done pulse is issued.
- States: IDLE, LINE1, EOL1, LINE2, EOL2, DONE.
- IDLE:
  - On i_start=1, latch i_ascii_line1 and i_ascii_line2 into internal snapshot registers, clear the char index, go to LINE1.
  - o_tx_valid rises on the next cycle (1-cycle latency from start).
- i_start is ignored in every state other than IDLE, with no queuing; the snapshot is not disturbed.
- Input line changes after the latch have no effect on the bytes sent.
- Handshake:
  - A byte is transferred on a cycle where o_tx_valid=1 and i_tx_ready=1.
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_valid hold stable.
  - o_tx_valid never drops without a transfer except on reset.
  - Back-to-back transfers at one byte per clock when i_tx_ready stays high; no bubble between states.
- LINE1 / LINE2:
  - Offer snapshot character [index], character 0 first.
  - Sanitise: bytes below 8'h20 or above 8'h7E are sent as 8'h2E ('.'); all others are sent unchanged.
  - After character PARM_LINE_CHARS-1 transfers: go to EOL1 (or EOL2) if PARM_EOL_CRLF=1, otherwise directly to LINE2 (or DONE).
- EOL states: offer 8'h0D, then 8'h0A; after the 8'h0A transfer, go to LINE2 (from EOL1) or DONE (from EOL2).
- Index counter: $clog2(PARM_LINE_CHARS) bits; resets to 0 on entry to each LINE state; never wraps mid-line.
- DONE:
  - Lasts one cycle: o_done=1, o_tx_valid=0, o_busy=1. Next state IDLE.
  - i_start asserted in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.
- Total transfers per request: 2*PARM_LINE_CHARS + (PARM_EOL_CRLF ? 4 : 0), i.e. 36 for defaults.
- o_tx_data outside a valid cycle is don't-care but held at its last value; reset value 8'h00.

Test Plan:
- Reset/idle: hold i_rst_20mhz_n=0 for 3 cycles, release with i_start=0 -> o_tx_valid=0, o_busy=0, o_done=0, o_tx_data=8'h00 for 10 cycles.
- Full stream, ready always high: line1="X:0123  Y:ABCD  ", line2="Z:0F00  T:0210  ", pulse i_start -> valid rises 1 cycle later; exactly 36 consecutive transfers "X:0123  Y:ABCD  \r\nZ:0F00  T:0210  \r\n"; o_done pulses one cycle after the 36th transfer; o_busy falls the cycle after that.
- Backpressure: same data, i_tx_ready toggling 1,0,0,1 repeating -> byte sequence identical to the previous scenario; o_tx_data stable through every not-ready cycle; 36 transfers total.
- Snapshot and start rejection: change both line inputs to all 8'h5F and pulse i_start again at transfer 5 -> output still matches the original text; no second transfer sequence starts after o_done.
- Sanitise and no-EOL: PARM_EOL_CRLF=0, line1 character 3 = 8'h0A and character 7 = 8'h7F -> those characters are sent as 8'h2E; 32 transfers with no 8'h0D/8'h0A present.
- Reset mid-operation: assert reset at transfer 20 -> o_tx_valid=0 the next cycle, no o_done; after release, a new i_start sends all 36 bytes from character 0 of line1.
